// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU codes, opcodes and FSM state encoding for the multicycle core
package riscv_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0100;
   localparam logic [3:0] ALU_XOR = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Only word loads/stores are supported
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EX_R,
      ST_EX_I,
      ST_MEM_ADDR,
      ST_MEM_RD,
      ST_MEM_WR,
      ST_WB_ALU,
      ST_WB_MEM,
      ST_BRANCH,
      ST_TRAP
   } state_t;

endpackage

// File: rtl/alu_dec.sv
// rtl/alu_dec.sv - maps funct3/funct7 bit 30 of an ALU instruction to an ALU op and a legal flag
module alu_dec
   import riscv_pkg::*;
(
   input  logic       is_r,
   input  logic [2:0] f3,
   input  logic       f7b,
   output logic [3:0] alu_op,
   output logic       legal
);

   // Funct decode; bit 30 selects SUB only for R-type, SRA for both R and I
   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b1;
      case (f3)
         3'b000:  alu_op = (is_r && f7b) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op = ALU_SLL;
         3'b010:  alu_op = ALU_SLT;
         3'b100:  alu_op = ALU_XOR;
         3'b101:  alu_op = f7b ? ALU_SRA : ALU_SRL;
         3'b110:  alu_op = ALU_OR;
         3'b111:  alu_op = ALU_AND;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// rtl/riscv_mc_ctrl.sv - multicycle RV32I control FSM: fetch, decode, execute, memory, writeback
module riscv_mc_ctrl
   import riscv_pkg::*;
#(
   parameter bit RESET_TRAP = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [3:0]  alu_op,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic        mem_read,
   output logic        mem_write,
   output logic        i_or_d,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        pc_src,
   output logic        retire,
   output logic        illegal
);

   state_t     state;
   state_t     state_nxt;
   logic       bad_instr;
   logic [6:0] opcode;
   logic [2:0] f3;
   logic [3:0] dec_op;
   logic       dec_legal;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];

   alu_dec u_alu_dec (
      .is_r   (opcode == OPC_R),
      .f3     (f3),
      .f7b    (instr[30]),
      .alu_op (dec_op),
      .legal  (dec_legal)
   );

   // State register; reset abandons any in-flight memory handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control decode; outputs not named in a state stay 0
   always_comb begin
      state_nxt  = state;
      bad_instr  = 1'b0;
      alu_op     = ALU_ADD;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      retire     = 1'b0;
      illegal    = 1'b0;

      case (state)
         ST_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'd1;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            // PC + imm lands in ALUOut as the speculative branch target
            alu_src_b = 2'd2;
            case (opcode)
               OPC_R: begin
                  if (dec_legal) state_nxt = ST_EX_R;
                  else           bad_instr = 1'b1;
               end
               OPC_I: begin
                  if (dec_legal) state_nxt = ST_EX_I;
                  else           bad_instr = 1'b1;
               end
               OPC_LOAD, OPC_STORE: state_nxt = ST_MEM_ADDR;
               OPC_BRANCH:          state_nxt = ST_BRANCH;
               default:             bad_instr = 1'b1;
            endcase
         end
         ST_EX_R: begin
            alu_src_a = 1'b1;
            alu_op    = dec_op;
            state_nxt = ST_WB_ALU;
         end
         ST_EX_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            alu_op    = dec_op;
            state_nxt = ST_WB_ALU;
         end
         ST_WB_ALU: begin
            reg_write = 1'b1;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
         end
         ST_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            if (f3 == F3_WORD) begin
               state_nxt = (opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            end else begin
               bad_instr = 1'b1;
            end
         end
         ST_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_nxt = ST_WB_MEM;
         end
         ST_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_nxt  = ST_FETCH;
         end
         ST_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               retire    = 1'b1;
               state_nxt = ST_FETCH;
            end
         end
         ST_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 1'b1;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
            case (f3)
               F3_BEQ:  pc_write  = zero;
               F3_BNE:  pc_write  = !zero;
               default: bad_instr = 1'b1;
            endcase
         end
         ST_TRAP: begin
            illegal = 1'b1;
         end
         default: state_nxt = ST_FETCH;
      endcase

      // Illegal instruction: either park in TRAP or retire it as a NOP
      if (bad_instr) begin
         if (RESET_TRAP) begin
            state_nxt = ST_TRAP;
            retire    = 1'b0;
         end else begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
         end
      end

      // Reset overrides every enable regardless of state
      if (!rst) begin
         alu_op     = ALU_ADD;
         alu_src_a  = 1'b0;
         alu_src_b  = 2'd0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         i_or_d     = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         reg_write  = 1'b0;
         mem_to_reg = 1'b0;
         pc_src     = 1'b0;
         retire     = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb/tb_riscv_mc_ctrl.sv - scoreboard bench for the multicycle control FSM, NOP and TRAP variants
module tb_riscv_mc_ctrl;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       src_a;
      logic [1:0] src_b;
      logic       mem_read;
      logic       mem_write;
      logic       i_or_d;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       pc_src;
      logic       retire;
      logic       illegal;
   } ctrl_t;

   typedef struct packed {
      ctrl_t c;
      ctrl_t ct;
      logic  rdy;
      logic  z;
      logic  rn;
   } step_t;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;

   logic [3:0]  alu_op, alu_op_t;
   logic        alu_src_a, alu_src_a_t;
   logic [1:0]  alu_src_b, alu_src_b_t;
   logic        mem_read, mem_read_t, mem_write, mem_write_t, i_or_d, i_or_d_t;
   logic        ir_write, ir_write_t, pc_write, pc_write_t, reg_write, reg_write_t;
   logic        mem_to_reg, mem_to_reg_t, pc_src, pc_src_t, retire, retire_t;
   logic        illegal, illegal_t;

   ctrl_t obs, obs_t;
   step_t sb[$];
   step_t s;
   int    tests  = 0;
   int    failed = 0;

   riscv_mc_ctrl #(.RESET_TRAP(1'b0)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
      .mem_to_reg(mem_to_reg), .pc_src(pc_src), .retire(retire), .illegal(illegal)
   );

   riscv_mc_ctrl #(.RESET_TRAP(1'b1)) dut_t (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
      .alu_op(alu_op_t), .alu_src_a(alu_src_a_t), .alu_src_b(alu_src_b_t),
      .mem_read(mem_read_t), .mem_write(mem_write_t), .i_or_d(i_or_d_t),
      .ir_write(ir_write_t), .pc_write(pc_write_t), .reg_write(reg_write_t),
      .mem_to_reg(mem_to_reg_t), .pc_src(pc_src_t), .retire(retire_t), .illegal(illegal_t)
   );

   assign obs   = {alu_op, alu_src_a, alu_src_b, mem_read, mem_write, i_or_d, ir_write,
                   pc_write, reg_write, mem_to_reg, pc_src, retire, illegal};
   assign obs_t = {alu_op_t, alu_src_a_t, alu_src_b_t, mem_read_t, mem_write_t, i_or_d_t,
                   ir_write_t, pc_write_t, reg_write_t, mem_to_reg_t, pc_src_t, retire_t,
                   illegal_t};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected control vectors for each state, taken from the state table
   function automatic ctrl_t mk(logic [3:0] op, logic a, logic [1:0] b, logic mr, logic mw,
                                logic iod, logic irw, logic pcw, logic rw, logic m2r,
                                logic pcs, logic ret, logic ill);
      return {op, a, b, mr, mw, iod, irw, pcw, rw, m2r, pcs, ret, ill};
   endfunction

   function automatic ctrl_t c_fetch(logic r); return mk(4'b0010,0,2'd1,1,0,0,r,r,0,0,0,0,0); endfunction
   function automatic ctrl_t c_dec(logic ret); return mk(4'b0010,0,2'd2,0,0,0,0,0,0,0,0,ret,0); endfunction
   function automatic ctrl_t c_ex(logic [3:0] op, logic [1:0] b); return mk(op,1,b,0,0,0,0,0,0,0,0,0,0); endfunction
   function automatic ctrl_t c_wba(); return mk(4'b0010,0,2'd0,0,0,0,0,0,1,0,0,1,0); endfunction
   function automatic ctrl_t c_ma(); return mk(4'b0010,1,2'd2,0,0,0,0,0,0,0,0,0,0); endfunction
   function automatic ctrl_t c_mrd(); return mk(4'b0010,0,2'd0,1,0,1,0,0,0,0,0,0,0); endfunction
   function automatic ctrl_t c_wbm(); return mk(4'b0010,0,2'd0,0,0,0,0,0,1,1,0,1,0); endfunction
   function automatic ctrl_t c_mwr(logic r); return mk(4'b0010,0,2'd0,0,1,1,0,0,0,0,0,r,0); endfunction
   function automatic ctrl_t c_br(logic pw); return mk(4'b0110,1,2'd0,0,0,0,0,pw,0,0,1,1,0); endfunction
   function automatic ctrl_t c_trap(); return mk(4'b0010,0,2'd0,0,0,0,0,0,0,0,0,0,1); endfunction
   function automatic ctrl_t c_rst(); return mk(4'b0010,0,2'd0,0,0,0,0,0,0,0,0,0,0); endfunction

   task automatic push2(ctrl_t c, ctrl_t ct, logic rdy, logic z, logic rn);
      step_t e;
      e.c = c; e.ct = ct; e.rdy = rdy; e.z = z; e.rn = rn;
      sb.push_back(e);
   endtask

   task automatic push(ctrl_t c, logic rdy, logic z);
      push2(c, c, rdy, z, 1'b1);
   endtask

   // Tasks are entered just after a falling edge; inputs are driven there and checked 1ns later
   task automatic test_reset();
      int cyc = 0;
      rst = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
      push2(c_rst(), c_rst(), 1'b1, 1'b0, 1'b0);
      push2(c_rst(), c_rst(), 1'b1, 1'b0, 1'b0);
      push(c_fetch(1'b0), 1'b0, 1'b0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         mem_ready = s.rdy; zero = s.z; rst = s.rn;
         #1;
         tests++;
         if (obs !== s.c || obs_t !== s.ct) begin
            failed++;
            $display("FAIL reset cyc %0d: got %h/%h want %h/%h", cyc, obs, obs_t, s.c, s.ct);
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_alu(string name, logic [31:0] ins, logic [3:0] op, logic [1:0] b);
      int cyc = 0;
      instr = ins;
      push(c_fetch(1'b1), 1'b1, 1'b0);
      push(c_dec(1'b0), 1'b1, 1'b1);
      push(c_ex(op, b), 1'b1, 1'b0);
      push(c_wba(), 1'b1, 1'b0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         mem_ready = s.rdy; zero = s.z; rst = s.rn;
         #1;
         tests++;
         if (obs !== s.c || obs_t !== s.ct) begin
            failed++;
            $display("FAIL %s cyc %0d: got %h/%h want %h/%h", name, cyc, obs, obs_t, s.c, s.ct);
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_load();
      int cyc = 0;
      instr = 32'h00812283;
      push(c_fetch(1'b1), 1'b1, 1'b0);
      push(c_dec(1'b0), 1'b0, 1'b0);
      push(c_ma(), 1'b0, 1'b0);
      push(c_mrd(), 1'b0, 1'b0);
      push(c_mrd(), 1'b0, 1'b0);
      push(c_mrd(), 1'b1, 1'b0);
      push(c_wbm(), 1'b1, 1'b0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         mem_ready = s.rdy; zero = s.z; rst = s.rn;
         #1;
         tests++;
         if (obs !== s.c || obs_t !== s.ct) begin
            failed++;
            $display("FAIL lw cyc %0d: got %h/%h want %h/%h", cyc, obs, obs_t, s.c, s.ct);
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [31:0] ins_tab[4] = '{32'h00208063, 32'h00208063, 32'h00209063, 32'h00209063};
      logic        z_tab[4]   = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic        pw_tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         int cyc = 0;
         instr = ins_tab[k];
         push(c_fetch(1'b0), 1'b0, 1'b0);
         push(c_fetch(1'b1), 1'b1, 1'b0);
         push(c_dec(1'b0), 1'b0, z_tab[k]);
         push(c_br(pw_tab[k]), 1'b1, z_tab[k]);
         while (sb.size() > 0) begin
            s = sb.pop_front();
            mem_ready = s.rdy; zero = s.z; rst = s.rn;
            #1;
            tests++;
            if (obs !== s.c || obs_t !== s.ct) begin
               failed++;
               $display("FAIL branch%0d cyc %0d: got %h/%h want %h/%h", k, cyc, obs, obs_t, s.c, s.ct);
            end
            cyc++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_trap();
      int cyc = 0;
      instr = 32'h0000007F;
      push(c_fetch(1'b1), 1'b1, 1'b0);
      push2(c_dec(1'b1), c_dec(1'b0), 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 22; i++) push2(c_fetch(1'b0), c_trap(), 1'b0, 1'b0, 1'b1);
      push2(c_rst(), c_rst(), 1'b1, 1'b0, 1'b0);
      push(c_fetch(1'b0), 1'b0, 1'b0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         mem_ready = s.rdy; zero = s.z; rst = s.rn;
         #1;
         tests++;
         if (obs !== s.c || obs_t !== s.ct) begin
            failed++;
            $display("FAIL trap cyc %0d: got %h/%h want %h/%h", cyc, obs, obs_t, s.c, s.ct);
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_store_reset();
      int cyc = 0;
      instr = 32'h00512423;
      push(c_fetch(1'b1), 1'b1, 1'b0);
      push(c_dec(1'b0), 1'b1, 1'b0);
      push(c_ma(), 1'b0, 1'b0);
      push(c_mwr(1'b0), 1'b0, 1'b0);
      push(c_mwr(1'b0), 1'b0, 1'b0);
      push2(c_rst(), c_rst(), 1'b1, 1'b0, 1'b0);
      push(c_fetch(1'b1), 1'b1, 1'b0);
      push(c_dec(1'b0), 1'b0, 1'b0);
      push(c_ma(), 1'b0, 1'b0);
      push(c_mwr(1'b1), 1'b1, 1'b0);
      push(c_fetch(1'b0), 1'b0, 1'b0);
      while (sb.size() > 0) begin
         s = sb.pop_front();
         mem_ready = s.rdy; zero = s.z; rst = s.rn;
         #1;
         tests++;
         if (obs !== s.c || obs_t !== s.ct) begin
            failed++;
            $display("FAIL sw_rst cyc %0d: got %h/%h want %h/%h", cyc, obs, obs_t, s.c, s.ct);
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_alu("sub",  32'h40B50533, 4'b0110, 2'd0);
      test_alu("srai", 32'h4030D093, 4'b1010, 2'd2);
      test_alu("addi", 32'h40008093, 4'b0010, 2'd2);
      test_load();
      test_branch();
      test_trap();
      test_store_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
